tdm_demux16: RTL and testbench
==============================

# tdm_demux16

Time-division demultiplexer: the receive end of the 16-channel nibble mux path. It accepts a framed serial stream of WIDTH-bit samples, one per slot, and distributes slots 0..15 into 16 channel registers. A completed frame is committed atomically to the output bank. A direct-addressed write port, selected by the split {s1,s0} select, allows single-channel updates between frames.

## Interface
Parameters:
- WIDTH, 4, sample width per channel; channel count is fixed at 16.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  serial sample for the current slot.
- din_valid  in  1  din is valid this cycle.
- sof  in  1  start of frame; qualifies din as slot 0; meaningful only with din_valid.
- wr_direct  in  1  direct write of din to channel {s1,s0}.
- s1  in  3  select, upper bits.
- s0  in  1  select, LSB; channel index = {s1,s0}.
- dout  out  16*WIDTH  committed bank; channel k at [WIDTH*k +: WIDTH].
- slot  out  4  next slot index expected.
- busy  out  1  high while in RECV.
- frame_done  out  1  one-cycle pulse on frame commit.
- frame_err  out  1  one-cycle pulse on truncated frame.

## Operation
- FSM states: IDLE, RECV.
- IDLE:
  - din_valid&sof: shadow[0]<=din, slot<=1, go RECV.
  - din_valid without sof: ignored, no error.
- RECV:
  - din_valid&!sof: shadow[slot]<=din, slot<=slot+1.
  - When slot==15 is accepted: dout<=shadow with slot 15 replaced by din, frame_done pulse, slot<=0, go IDLE.
  - din_valid&sof mid-frame: frame_err pulse. The partial shadow is discarded (not committed), shadow[0]<=din, slot<=1, stay in RECV.
  - !din_valid: hold state; there is no timeout.
- Direct write: wr_direct with !din_valid writes dout[{s1,s0}]<=din.
  - wr_direct together with din_valid is ignored; the stream has priority.
  - A direct write in the commit cycle is lost; the commit wins.
- Shadow bank is internal; dout changes only on commit or direct write.
- slot is a 4-bit counter; it wraps 15->0 only via commit.

## Timing
- Reset values: dout=0, shadow=0, slot=0, busy=0, frame_done=0, frame_err=0, state=IDLE.
- Reset mid-frame discards the partial frame and leaves no pending commit.
- Sample acceptance is registered at the edge where din_valid=1.
- Commit latency: dout and frame_done are visible in the cycle after the 16th sample's accepting edge.
  - Minimum frame length is 16 consecutive valid cycles; frame_done then rises in cycle 17 after sof.
- Back-to-back frames: sof may arrive in the cycle immediately after the 16th sample, i.e. the cycle frame_done is high, with no bubble.
- frame_err is asserted in the cycle after the offending sof edge.
- Direct write latency: 1 cycle.
- All outputs are registered; there are no combinational in-to-out paths.

## Structure
- Shared package tdm_pkg:
  - NUM_CH=16, SLOT_W=4, state enum {IDLE, RECV}.
  - Channel-slice helper constant WIDTH default.
- Sub-module tdm_chan_bank: 16xWIDTH register file with one indexed write port and a parallel full-bank load. Instantiate it twice, once for the shadow bank and once for the committed bank.
- Top level holds the FSM, slot counter and write arbitration.

## Test plan
- Reset, then one frame: sof with din=0, then din=1..15 on consecutive cycles -> dout=64'hFEDCBA9876543210 and frame_done=1 in the following cycle; slot=0, busy=0.
- Gapped frame: the same data with din_valid deasserted for 3 cycles after slot 7 -> identical dout; the commit is 3 cycles later; dout stays unchanged until commit.
- Truncated frame: sof plus 5 samples of 4'hA, then a new sof and a full frame of 4'h3 -> frame_err pulses once; final dout is all 4'h3; no commit of 4'hA.
- Direct write: with the bank cleared, wr_direct, s1=3'b101, s0=1, din=4'h9 -> only channel 11 = 9 the next cycle. Repeat with din_valid=1 -> write ignored.
- Collisions: wr_direct to channel 2 in the commit cycle -> channel 2 holds the frame value. Two back-to-back frames with sof directly after the 16th sample -> two frame_done pulses 16 cycles apart.
- Reset mid-frame: rst asserted after 9 samples, then a new full frame of 4'h5 -> dout=0 until that frame commits, then all 4'h5; no frame_err.

Source files
------------

// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 16-channel TDM receive path.
//   NUM_CH        : number of channels / slots per frame (fixed at 16)
//   SLOT_W        : width of a slot index
//   WIDTH_DEFAULT : default sample width per channel
//   tdm_state_e   : receiver FSM state encoding
//   is_last_slot(): true when a slot index is the final slot of a frame
// ---------------------------------------------------------------------------
package tdm_pkg;

  localparam int NUM_CH        = 16;
  localparam int SLOT_W        = 4;
  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  function automatic logic is_last_slot(input logic [SLOT_W-1:0] idx);
    return idx == SLOT_W'(NUM_CH - 1);
  endfunction

endpackage : tdm_pkg

// File: rtl/tdm_chan_bank.sv
// ---------------------------------------------------------------------------
// tdm_chan_bank
// NUM_CH x WIDTH register file with one indexed write port and a parallel
// full-bank load. The bank load has priority over the indexed write.
// Ports:
//   clk         : rising-edge clock
//   rst_i       : synchronous active-high reset, clears every channel
//   wr_en_i     : indexed write enable
//   wr_idx_i    : channel index for the indexed write
//   wr_data_i   : data for the indexed write
//   load_en_i   : load all channels from load_data_i
//   load_data_i : flat bank image, channel k at [WIDTH*k +: WIDTH]
//   rd_data_o   : flat view of the current bank contents
// ---------------------------------------------------------------------------
module tdm_chan_bank
  import tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [SLOT_W-1:0]       wr_idx_i,
  input  logic [WIDTH-1:0]        wr_data_i,
  input  logic                    load_en_i,
  input  logic [NUM_CH*WIDTH-1:0] load_data_i,
  output logic [NUM_CH*WIDTH-1:0] rd_data_o
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] ch_q;

    always_ff @(posedge clk) begin
      if (rst_i) begin
        ch_q <= '0;
      end else if (load_en_i) begin
        ch_q <= load_data_i[gi*WIDTH +: WIDTH];
      end else if (wr_en_i && (wr_idx_i == SLOT_W'(gi))) begin
        ch_q <= wr_data_i;
      end
    end

    assign rd_data_o[gi*WIDTH +: WIDTH] = ch_q;
  end

endmodule : tdm_chan_bank

// File: rtl/tdm_demux16.sv
// ---------------------------------------------------------------------------
// tdm_demux16
// Receive end of the 16-channel TDM path. Serial samples (one per slot) are
// collected into a shadow bank; when slot 15 is accepted the whole frame is
// committed to the output bank in one edge. A direct write port updates a
// single output channel between frames.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   din        : sample for the current slot / direct-write data
//   din_valid  : din carries a stream sample this cycle
//   sof        : start of frame, qualifies din as slot 0 (with din_valid)
//   wr_direct  : direct write of din to channel {s1,s0} (only when !din_valid)
//   s1, s0     : direct-write channel select, index = {s1,s0}
//   dout       : committed bank, channel k at [WIDTH*k +: WIDTH]
//   slot       : next slot index expected
//   busy       : high while a frame is being received
//   frame_done : one-cycle pulse in the cycle after a commit edge
//   frame_err  : one-cycle pulse after a sof that truncated a frame
// ---------------------------------------------------------------------------
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic                    sof,
  input  logic                    wr_direct,
  input  logic [2:0]              s1,
  input  logic                    s0,
  output logic [NUM_CH*WIDTH-1:0] dout,
  output logic [SLOT_W-1:0]       slot,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_err
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  tdm_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              busy_q;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;

  // Bank control
  logic                    shadow_we;
  logic [SLOT_W-1:0]       shadow_idx;
  logic                    commit;
  logic                    direct_we;
  logic [NUM_CH*WIDTH-1:0] shadow_flat;
  logic [NUM_CH*WIDTH-1:0] commit_data;
  logic [SLOT_W-1:0]       direct_idx;

  assign direct_idx = {s1, s0};

  // -------------------------------------------------------------------------
  // Next-state / control logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    shadow_we    = 1'b0;
    shadow_idx   = slot_q;
    commit       = 1'b0;

    // The stream owns the cycle whenever din_valid is high, so a direct
    // write can never coincide with a commit (which needs din_valid).
    direct_we = wr_direct && !din_valid;

    unique case (state_q)
      IDLE: begin
        // Samples without sof between frames are silently dropped.
        if (din_valid && sof) begin
          shadow_we  = 1'b1;
          shadow_idx = '0;
          slot_d     = SLOT_W'(1);
          state_d    = RECV;
        end
      end

      RECV: begin
        if (din_valid) begin
          shadow_we = 1'b1;
          if (sof) begin
            // Restart: the partial frame is simply overwritten by the new
            // one; it is never committed because commit needs slot 15.
            frame_err_d = 1'b1;
            shadow_idx  = '0;
            slot_d      = SLOT_W'(1);
          end else if (is_last_slot(slot_q)) begin
            commit       = 1'b1;
            frame_done_d = 1'b1;
            slot_d       = '0;
            state_d      = IDLE;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        slot_d  = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      busy_q       <= (state_d == RECV);
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Banks
  // -------------------------------------------------------------------------
  // Slot 15 is never read back from the shadow: it lands in the output bank
  // straight from din on the commit edge.
  always_comb begin
    commit_data                     = shadow_flat;
    commit_data[WIDTH*15 +: WIDTH]  = din;
  end

  tdm_chan_bank #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk         (clk),
    .rst_i       (rst),
    .wr_en_i     (shadow_we),
    .wr_idx_i    (shadow_idx),
    .wr_data_i   (din),
    .load_en_i   (1'b0),
    .load_data_i ('0),
    .rd_data_o   (shadow_flat)
  );

  tdm_chan_bank #(
    .WIDTH (WIDTH)
  ) u_committed (
    .clk         (clk),
    .rst_i       (rst),
    .wr_en_i     (direct_we),
    .wr_idx_i    (direct_idx),
    .wr_data_i   (din),
    .load_en_i   (commit),
    .load_data_i (commit_data),
    .rd_data_o   (dout)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign slot       = slot_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule : tdm_demux16

// File: tb/tb_tdm_demux16.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux16
// Directed scenarios followed by randomized traffic. A frame-level model
// (queue of collected samples + expected output bank) is updated after every
// clock edge; a compare process checks all outputs on every falling edge.
// ---------------------------------------------------------------------------
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        sof = 1'b0;
  logic        wr_direct = 1'b0;
  logic [2:0]  s1 = '0;
  logic        s0 = 1'b0;
  logic [63:0] dout;
  logic [3:0]  slot;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  always #5 clk = ~clk;

  tdm_demux16 #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .wr_direct  (wr_direct),
    .s1         (s1),
    .s0         (s0),
    .dout       (dout),
    .slot       (slot),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [3:0]  frame_q[$];
  bit          in_frame = 1'b0;
  logic [63:0] exp_dout = '0;
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a frame is any run of 16 accepted samples starting at
  // a sof; whatever happens in between only changes the collected list.
  task automatic model_edge(input logic r, input logic v, input logic s,
                            input logic [3:0] d, input logic wd,
                            input logic [2:0] a1, input logic a0);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (r) begin
      exp_dout = '0;
      frame_q.delete();
      in_frame = 1'b0;
    end else if (v) begin
      if (s) begin
        if (in_frame) exp_err = 1'b1;
        frame_q.delete();
        frame_q.push_back(d);
        in_frame = 1'b1;
      end else if (in_frame) begin
        frame_q.push_back(d);
        if (frame_q.size() == 16) begin
          for (int k = 0; k < 16; k++) exp_dout[4*k +: 4] = frame_q[k];
          exp_done = 1'b1;
          in_frame = 1'b0;
          frame_q.delete();
        end
      end
    end else if (wd) begin
      exp_dout[4*int'({a1, a0}) +: 4] = d;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s,
                      input logic [3:0] d, input logic wd,
                      input logic [2:0] a1, input logic a0);
    rst = r; din_valid = v; sof = s; din = d; wr_direct = wd; s1 = a1; s0 = a0;
    @(posedge clk);
    model_edge(r, v, s, d, wd, a1, a0);
    cyc++;
    #1;
  endtask

  task automatic sample(input logic [3:0] d, input logic s);
    step(1'b0, 1'b1, s, d, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
  endtask

  // Compare process: every output, every cycle, against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout",       dout,              exp_dout);
      chk("slot",       64'(slot),         64'(in_frame ? frame_q.size() : 0));
      chk("busy",       64'(busy),         64'(in_frame));
      chk("frame_done", 64'(frame_done),   64'(exp_done));
      chk("frame_err",  64'(frame_err),    64'(exp_err));
    end
  end

  int done_cnt;
  int err_cnt;
  int t1;
  int t2;

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
    chk_en = 1'b1;
    idle();
    chk("rst_dout", dout, 64'h0);
    chk("rst_slot", 64'(slot), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_flags", 64'({frame_done, frame_err}), 64'h0);

    // One frame 0..15
    sample(4'h0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      sample(4'(i), 1'b0);
      if (i < 15) chk("f1_hold", dout, 64'h0);
    end
    chk("f1_dout", dout, 64'hFEDCBA9876543210);
    chk("f1_done", 64'(frame_done), 64'h1);
    chk("f1_slot_busy", 64'({slot, busy}), 64'h0);
    idle();
    chk("f1_done_pulse", 64'(frame_done), 64'h0);

    // Gapped frame from a cleared bank
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
    sample(4'h0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      sample(4'(i), 1'b0);
      if (i == 7) begin
        for (int g = 0; g < 3; g++) begin
          idle();
          chk("gap_hold", dout, 64'h0);
          chk("gap_slot", 64'(slot), 64'h8);
        end
      end
    end
    chk("gap_dout", dout, 64'hFEDCBA9876543210);
    chk("gap_done", 64'(frame_done), 64'h1);

    // Truncated frame then full frame of 3s
    err_cnt = 0;
    sample(4'hA, 1'b1);
    for (int i = 0; i < 5; i++) sample(4'hA, 1'b0);
    sample(4'h3, 1'b1);
    if (frame_err) err_cnt++;
    for (int i = 1; i < 16; i++) begin
      sample(4'h3, 1'b0);
      if (frame_err) err_cnt++;
    end
    chk("trunc_err_once", 64'(err_cnt), 64'h1);
    chk("trunc_dout", dout, 64'h3333333333333333);

    // Direct write
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h9, 1'b1, 3'b101, 1'b1);
    chk("direct_ch11", dout, 64'h0000900000000000);
    step(1'b0, 1'b1, 1'b0, 4'h7, 1'b1, 3'b101, 1'b1);
    chk("direct_ignored", dout, 64'h0000900000000000);

    // Direct write in the commit cycle loses to the commit
    sample(4'hC, 1'b1);
    for (int i = 1; i < 15; i++) sample(4'hC, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'hC, 1'b1, 3'b001, 1'b0);
    chk("collide_dout", dout, 64'hCCCCCCCCCCCCCCCC);

    // Back-to-back frames
    done_cnt = 0; t1 = 0; t2 = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        sample(4'(15 - i + f), i == 0);
        if (frame_done) begin
          done_cnt++;
          if (done_cnt == 1) t1 = cyc; else t2 = cyc;
        end
      end
    end
    chk("b2b_count", 64'(done_cnt), 64'h2);
    chk("b2b_gap", 64'(t2 - t1), 64'd16);
    chk("b2b_dout", dout, 64'h123456789ABCDEF0);

    // Reset mid-frame
    sample(4'h8, 1'b1);
    for (int i = 1; i < 9; i++) sample(4'h8, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
    err_cnt = 0;
    sample(4'h5, 1'b1);
    for (int i = 1; i < 16; i++) begin
      chk("midrst_hold", dout, 64'h0);
      if (frame_err) err_cnt++;
      sample(4'h5, 1'b0);
    end
    chk("midrst_dout", dout, 64'h5555555555555555);
    chk("midrst_noerr", 64'(err_cnt), 64'h0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 39) == 0,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end

    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_tdm_demux16
